// File: rtl/if_id_stall_unit.sv
// PC register, IF/ID register and the control half of ID/EX, with stall, bubble and
// branch-flush handling. Every output comes straight from a flop.
module if_id_stall_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 8,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pc_write,
    input  logic              if_id_write,
    input  logic              load_delay,
    input  logic              flush,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       imem_inst,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [31:0]       pc_out,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_inst,
    output logic              if_id_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [31:0]      NOP_INST = 32'h0000_0013;
    localparam logic [31:0]      PC_STEP  = 32'd4;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       if_id_pc_q, if_id_pc_d;
    logic [31:0]       if_id_inst_q, if_id_inst_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        ex_ctrl_d     = ex_ctrl_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;

        if (flush) begin
            // A taken branch overrides every hold/bubble request this cycle.
            pc_d          = branch_target;
            if_id_pc_d    = 32'h0000_0000;
            if_id_inst_d  = NOP_INST;
            if_id_valid_d = 1'b0;
            ex_ctrl_d     = '0;
            if (flush_count_q != CNT_MAX) begin
                flush_count_d = flush_count_q + CNT_ONE;
            end
        end else begin
            if (pc_write) begin
                pc_d = pc_q + PC_STEP;
            end
            if (if_id_write) begin
                if_id_pc_d    = pc_q;
                if_id_inst_d  = imem_inst;
                if_id_valid_d = 1'b1;
            end
            // Control from a squashed IF/ID slot must never reach EX.
            if (load_delay) begin
                ex_ctrl_d = '0;
            end else if (if_id_valid_q) begin
                ex_ctrl_d = id_ctrl;
            end else begin
                ex_ctrl_d = '0;
            end
            if (load_delay && (stall_count_q != CNT_MAX)) begin
                stall_count_d = stall_count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
            ex_ctrl_q     <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign pc_out      = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_valid = if_id_valid_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
